fpcvt: RTL and testbench



---
 rtl/fpcvt_pkg.sv | 73 +++++++
 rtl/fpcvt_lzc32.sv | 17 +
 rtl/fpcvt.sv | 230 +++++++++++++++++++++++
 tb/tb_fpcvt.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpcvt_pkg.sv
// Shared encodings, constants and stage-register layouts for the fpcvt converter.
package fpcvt_pkg;

    typedef enum logic [1:0] {
        OP_W_S  = 2'b00,
        OP_WU_S = 2'b01,
        OP_S_W  = 2'b10,
        OP_S_WU = 2'b11
    } fpcvt_op_e;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } fpcvt_rm_e;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;
    localparam int          EXP_BIAS = 127;

    // Unpacked operand: float fields, or integer magnitude plus its leading-zero count.
    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  rm;
        logic        sign;
        logic [7:0]  exp;
        logic [31:0] sig;
        logic [5:0]  lzc;
        logic        is_nan;
        logic        is_inf;
        logic        is_zero;
    } s1_t;

    // Aligned value: 32 integer/mantissa bits followed by guard, round and sticky.
    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  rm;
        logic        sign;
        logic [7:0]  exp;
        logic [31:0] mag;
        logic        g;
        logic        r;
        logic        st;
        logic        is_nan;
        logic        is_inf;
        logic        is_zero;
        logic        huge;
    } s2_t;

    // Decides whether the kept magnitude is incremented; reserved modes fall back to RNE.
    function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                      input logic lsb, input logic half, input logic below);
        logic inexact;
        inexact = half | below;
        case (rm)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = sign & inexact;
            RM_RUP:  round_up = !sign & inexact;
            RM_RMM:  round_up = half;
            default: round_up = half & (below | lsb);
        endcase
    endfunction

endpackage

// File: rtl/fpcvt_lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero input yields 32.
module lzc32 (
    input  logic [31:0] a,
    output logic [5:0]  cnt
);

    // Scanning upward lets the highest set bit have the final say.
    always_comb begin
        cnt = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) begin
                cnt = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/fpcvt.sv
// Three-stage IEEE 754 single <-> 32-bit integer converter with valid/ready on both sides.
// Optional macro FPCVT_RM_EN adds a per-operand rounding-mode port; without it only RNE is used.
module fpcvt
    import fpcvt_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
`ifdef FPCVT_RM_EN
    input  logic [2:0]  rm,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic [4:0]  flags
);

    localparam int LATENCY = 3;

    logic               adv;
    logic [2:0]         rm_in;
    logic [LATENCY-1:0] vld_q, vld_d;
    s1_t                s1_q, s1_d, s1_new;
    s2_t                s2_q, s2_d, s2_new;
    logic [31:0]        out_q, out_d;
    logic [4:0]         flags_q, flags_d;

    logic [31:0]        int_mag;
    logic [5:0]         lzc_cnt;

    logic [65:0]        f2i_base, f2i_fx;
    logic [7:0]         f2i_sh;
    logic [31:0]        i2f_norm;

    logic               s3_below, s3_inexact, s3_up, s3_nv, s3_nx;
    logic [32:0]        s3_rnd;
    logic [23:0]        s3_frac;
    logic [7:0]         s3_exp;
    logic [31:0]        s3_res;
    logic [4:0]         s3_flags;

`ifdef FPCVT_RM_EN
    assign rm_in = rm;
`else
    assign rm_in = RM_RNE;
`endif

    assign adv       = !vld_q[LATENCY-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[LATENCY-1];
    assign out       = out_q;
    assign flags     = flags_q;

    assign int_mag = (op == OP_S_W && rs1[31]) ? -rs1 : rs1;

    lzc32 u_lzc (
        .a   (int_mag),
        .cnt (lzc_cnt)
    );

    // Stage 1: unpack the float (subnormals take exponent 1, no hidden bit) or take |int|.
    always_comb begin
        s1_new    = '0;
        s1_new.op = op;
        s1_new.rm = rm_in;
        if (op[1]) begin
            s1_new.sign    = (op == OP_S_W) && rs1[31];
            s1_new.sig     = int_mag;
            s1_new.lzc     = lzc_cnt;
            s1_new.is_zero = (rs1 == 32'd0);
        end else begin
            s1_new.sign    = rs1[31];
            s1_new.exp     = (rs1[30:23] == 8'd0) ? 8'd1 : rs1[30:23];
            s1_new.sig     = {8'b0, |rs1[30:23], rs1[22:0]};
            s1_new.is_nan  = (rs1[30:23] == 8'hFF) && (rs1[22:0] != 23'd0);
            s1_new.is_inf  = (rs1[30:23] == 8'hFF) && (rs1[22:0] == 23'd0);
            s1_new.is_zero = (rs1[30:0] == 31'd0);
        end
        s1_d = adv ? s1_new : s1_q;
    end

    // Stage 2: the float path places the significand with its binary point at bit 34,
    // so anything shifted further right than that can only contribute to sticky.
    always_comb begin
        s2_new         = '0;
        f2i_base       = '0;
        f2i_fx         = '0;
        f2i_sh         = '0;
        i2f_norm       = '0;
        s2_new.op      = s1_q.op;
        s2_new.rm      = s1_q.rm;
        s2_new.sign    = s1_q.sign;
        s2_new.is_nan  = s1_q.is_nan;
        s2_new.is_inf  = s1_q.is_inf;
        s2_new.is_zero = s1_q.is_zero;
        if (s1_q.op[1]) begin
            i2f_norm   = s1_q.sig << s1_q.lzc;
            s2_new.exp = 8'(EXP_BIAS + 31) - {2'b00, s1_q.lzc};
            s2_new.mag = {8'b0, i2f_norm[31:8]};
            s2_new.g   = i2f_norm[7];
            s2_new.r   = i2f_norm[6];
            s2_new.st  = |i2f_norm[5:0];
        end else begin
            f2i_base = {8'b0, s1_q.sig[23:0], 34'b0};
            if (s1_q.exp >= 8'd150) begin
                f2i_sh = s1_q.exp - 8'd150;
                if (f2i_sh > 8'd8) begin
                    s2_new.huge = 1'b1;
                end else begin
                    f2i_fx = f2i_base << f2i_sh[3:0];
                end
            end else begin
                f2i_sh = 8'd150 - s1_q.exp;
                if (f2i_sh > 8'd34) begin
                    f2i_fx = {65'b0, |s1_q.sig[23:0]};
                end else begin
                    f2i_fx = f2i_base >> f2i_sh[5:0];
                end
            end
            s2_new.mag = f2i_fx[65:34];
            s2_new.g   = f2i_fx[33];
            s2_new.r   = f2i_fx[32];
            s2_new.st  = |f2i_fx[31:0];
        end
        s2_d = adv ? s2_new : s2_q;
    end

    // Stage 3: round first, then saturate, so overflow reflects the rounded value.
    always_comb begin
        s3_below   = s2_q.r | s2_q.st;
        s3_inexact = s2_q.g | s3_below;
        s3_up      = round_up(s2_q.rm, s2_q.sign, s2_q.mag[0], s2_q.g, s3_below);
        s3_rnd     = {1'b0, s2_q.mag} + 33'(s3_up);
        s3_frac    = {1'b0, s2_q.mag[22:0]} + 24'(s3_up);
        s3_exp     = s2_q.exp + 8'(s3_frac[23]);
        s3_nv      = 1'b0;
        s3_nx      = 1'b0;
        s3_res     = '0;
        if (s2_q.op[1]) begin
            s3_res = s2_q.is_zero ? 32'd0 : {s2_q.sign, s3_exp, s3_frac[22:0]};
            s3_nx  = s3_inexact;
        end else if (s2_q.is_nan) begin
            s3_res = (s2_q.op == OP_WU_S) ? UINT_MAX : INT_MAX;
            s3_nv  = 1'b1;
        end else if (s2_q.is_inf || s2_q.huge) begin
            if (s2_q.sign) begin
                s3_res = (s2_q.op == OP_WU_S) ? 32'd0 : INT_MIN;
            end else begin
                s3_res = (s2_q.op == OP_WU_S) ? UINT_MAX : INT_MAX;
            end
            s3_nv = 1'b1;
        end else if (s2_q.op == OP_WU_S) begin
            if (s2_q.sign) begin
                if (s3_rnd != 33'd0) begin
                    s3_nv = 1'b1;
                end else begin
                    s3_nx = s3_inexact;
                end
            end else if (s3_rnd[32]) begin
                s3_res = UINT_MAX;
                s3_nv  = 1'b1;
            end else begin
                s3_res = s3_rnd[31:0];
                s3_nx  = s3_inexact;
            end
        end else begin
            if (s2_q.sign) begin
                if (s3_rnd > {1'b0, INT_MIN}) begin
                    s3_res = INT_MIN;
                    s3_nv  = 1'b1;
                end else begin
                    s3_res = -s3_rnd[31:0];
                    s3_nx  = s3_inexact;
                end
            end else if (s3_rnd > {1'b0, INT_MAX}) begin
                s3_res = INT_MAX;
                s3_nv  = 1'b1;
            end else begin
                s3_res = s3_rnd[31:0];
                s3_nx  = s3_inexact;
            end
        end
`ifdef FPCVT_RM_EN
        if (s2_q.rm > RM_RMM) begin
            s3_nv = 1'b1;
            if (!s2_q.op[1]) begin
                s3_nx = 1'b0;
            end
        end
`endif
        s3_flags          = '0;
        s3_flags[FLAG_NV] = s3_nv;
        s3_flags[FLAG_DZ] = 1'b0;
        s3_flags[FLAG_OF] = 1'b0;
        s3_flags[FLAG_UF] = 1'b0;
        s3_flags[FLAG_NX] = s3_nx;
    end

    // Every stage moves together on adv; the output register is zeroed when fed a bubble.
    always_comb begin
        vld_d   = vld_q;
        out_d   = out_q;
        flags_d = flags_q;
        if (adv) begin
            vld_d   = {vld_q[LATENCY-2:0], in_valid};
            out_d   = vld_q[LATENCY-2] ? s3_res : 32'd0;
            flags_d = vld_q[LATENCY-2] ? s3_flags : 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            vld_q   <= vld_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_fpcvt.sv
// Scoreboard bench for fpcvt: the driver queues expected results, a negedge monitor checks them.
module tb_fpcvt;
    import fpcvt_pkg::*;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_NV   = 5'b10000;
    localparam logic [4:0] F_NX   = 5'b00001;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic [4:0]  flags;

    typedef struct {
        string       name;
        logic [31:0] y;
        logic [4:0]  f;
        int          acc_cyc;
        bit          lat_chk;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] y;
        logic [4:0]  f;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[19];
    int   checks = 0;
    int   failures = 0;
    int   popped = 0;
    int   cyc = 0;
    int   pop_base;

    fpcvt dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called at posedge+1; holds the operand until accepted, leaving in_valid high for back-to-back use.
    task automatic applyStimulus(input string name, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] y, input logic [4:0] f, input bit lat);
        exp_t e;
        int   n;
        op       = o;
        rs1      = a;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s accept timeout: in_ready=%b, required 1", name, in_ready);
        end else begin
            e.name    = name;
            e.y       = y;
            e.f       = f;
            e.acc_cyc = cyc;
            e.lat_chk = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " drained"}, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (resetn && out_valid === 1'b1 && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected result: out=0x%08h flags=%b, required no output", out, flags);
            end else begin
                mon_e = sb.pop_front();
                popped++;
                checkOutput({mon_e.name, " out"}, out, mon_e.y);
                checkOutput({mon_e.name, " flags"}, 32'(flags), 32'(mon_e.f));
                if (mon_e.lat_chk) begin
                    checkOutput({mon_e.name, " latency"}, 32'(cyc - mon_e.acc_cyc), 32'd3);
                end
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs = '{
            '{"sw_sticky",    OP_S_W,  32'h0100_0001, 32'h4B80_0000, F_NX},
            '{"sw_intmin",    OP_S_W,  32'h8000_0000, 32'hCF00_0000, F_NONE},
            '{"swu_max",      OP_S_WU, 32'hFFFF_FFFF, 32'h4F80_0000, F_NX},
            '{"sw_neg1",      OP_S_W,  32'hFFFF_FFFF, 32'hBF80_0000, F_NONE},
            '{"sw_zero",      OP_S_W,  32'h0000_0000, 32'h0000_0000, F_NONE},
            '{"ws_m2p5",      OP_W_S,  32'hC020_0000, 32'hFFFF_FFFE, F_NX},
            '{"ws_half",      OP_W_S,  32'h3F00_0000, 32'h0000_0000, F_NX},
            '{"wus_mhalf",    OP_WU_S, 32'hBF00_0000, 32'h0000_0000, F_NX},
            '{"ws_2p31",      OP_W_S,  32'h4F00_0000, 32'h7FFF_FFFF, F_NV},
            '{"wus_2p31",     OP_WU_S, 32'h4F00_0000, 32'h8000_0000, F_NONE},
            '{"ws_nan",       OP_W_S,  32'h7FC0_0000, 32'h7FFF_FFFF, F_NV},
            '{"wus_ninf",     OP_WU_S, 32'hFF80_0000, 32'h0000_0000, F_NV},
            '{"ws_maxexact",  OP_W_S,  32'h4EFF_FFFF, 32'h7FFF_FF80, F_NONE},
            '{"ws_m2p31",     OP_W_S,  32'hCF00_0000, 32'h8000_0000, F_NONE},
            '{"ws_1p5",       OP_W_S,  32'h3FC0_0000, 32'h0000_0002, F_NX},
            '{"ws_denorm",    OP_W_S,  32'h0000_0001, 32'h0000_0000, F_NX},
            '{"wus_m1",       OP_WU_S, 32'hBF80_0000, 32'h0000_0000, F_NV},
            '{"wus_2p32",     OP_WU_S, 32'h4F80_0000, 32'hFFFF_FFFF, F_NV},
            '{"ws_ninf",      OP_W_S,  32'hFF80_0000, 32'h8000_0000, F_NV}
        };

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out", out, 32'd0);
        checkOutput("reset flags", 32'(flags), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        applyStimulus("sw_one", OP_S_W, 32'd1, 32'h3F80_0000, F_NONE, 1'b1);
        in_valid = 1'b0;
        waitDrain("sw_one");

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].y, vecs[i].f, 1'b0);
        end
        in_valid = 1'b0;
        waitDrain("vectors");

        pop_base = popped;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    applyStimulus($sformatf("bp%0d", i), OP_S_W, 32'(i + 2),
                                  32'h4000_0000 + (i == 0 ? 32'h0 : (i == 1 ? 32'h0040_0000 :
                                  (i == 2 ? 32'h0080_0000 : (i == 3 ? 32'h00A0_0000 :
                                  (i == 4 ? 32'h00C0_0000 : 32'h00E0_0000))))),
                                  F_NONE, 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stall in_ready", 32'(in_ready), 32'd0);
                    checkOutput("stall out_valid", 32'(out_valid), 32'd1);
                    checkOutput("stall out", out, 32'h4000_0000);
                    checkOutput("stall flags", 32'(flags), 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain("backpressure");
        checkOutput("backpressure count", 32'(popped - pop_base), 32'd6);

        applyStimulus("rst_a", OP_S_W, 32'd1, 32'h3F80_0000, F_NONE, 1'b0);
        applyStimulus("rst_b", OP_S_W, 32'd2, 32'h4000_0000, F_NONE, 1'b0);
        applyStimulus("rst_c", OP_S_W, 32'd3, 32'h4040_0000, F_NONE, 1'b0);
        in_valid = 1'b0;
        resetn   = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset out", out, 32'd0);
        checkOutput("midreset flags", 32'(flags), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus("post_reset", OP_S_W, 32'd1, 32'h3F80_0000, F_NONE, 1'b1);
        in_valid = 1'b0;
        waitDrain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
